// File: rtl/cond_flags_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cond_pkg : shared types and constants for the condition/flags stage        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package cond_pkg;

   typedef enum logic [3:0] {
      EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
      MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
      HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
      GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
   } cond_t;

   localparam int FLAG_Z = 0;
   localparam int FLAG_N = 1;
   localparam int FLAG_C = 2;
   localparam int FLAG_V = 3;

   localparam int FW_NZ = 1;
   localparam int FW_CV = 0;

   typedef struct packed {
      logic pcs;
      logic reg_w;
      logic mem_w;
      logic valid;
   } m_ctl_t;

   // ALU reports a borrow on SUB; the architectural C bit means "no borrow".
   function automatic logic arm_carry(input logic alu_c, input logic is_sub);
      return is_sub ? ~alu_c : alu_c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/cond_flags_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cond_flags_stage_if : E-stage inputs and M-stage outputs of the flags stage|
// | Optional squash_cnt signal present only with COND_SQUASH_CNT_EN.           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface cond_flags_stage_if #(
   parameter int CNT_W = 16
);
   logic             en;
   logic             flush;
   logic             valid_e;
   logic [3:0]       cond_e;
   logic [1:0]       flag_w_e;
   logic [3:0]       alu_flags;
   logic             alu_sub;
   logic             pcs_e;
   logic             reg_w_e;
   logic             mem_w_e;
   logic             no_write_e;
   logic             cond_ex_e;
   logic [3:0]       flags_q;
   logic             pcs_m;
   logic             reg_w_m;
   logic             mem_w_m;
   logic             valid_m;
`ifdef COND_SQUASH_CNT_EN
   logic [CNT_W-1:0] squash_cnt;
`endif

   modport master (
      output en, flush, valid_e, cond_e, flag_w_e, alu_flags, alu_sub,
             pcs_e, reg_w_e, mem_w_e, no_write_e,
      input  cond_ex_e, flags_q, pcs_m, reg_w_m, mem_w_m, valid_m
`ifdef COND_SQUASH_CNT_EN
           , squash_cnt
`endif
   );

   modport slave (
      input  en, flush, valid_e, cond_e, flag_w_e, alu_flags, alu_sub,
             pcs_e, reg_w_e, mem_w_e, no_write_e,
      output cond_ex_e, flags_q, pcs_m, reg_w_m, mem_w_m, valid_m
`ifdef COND_SQUASH_CNT_EN
           , squash_cnt
`endif
   );

endinterface
`default_nettype wire

// File: rtl/cond_flags_stage_cond_check.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cond_check : combinational ARM condition evaluation against {V,C,N,Z}      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module cond_check
   import cond_pkg::*;
(
   input  cond_t      cond,
   input  logic [3:0] flags,
   output logic       pass
);

   logic z;
   logic n;
   logic c;
   logic v;

   always_comb begin
      z    = flags[FLAG_Z];
      n    = flags[FLAG_N];
      c    = flags[FLAG_C];
      v    = flags[FLAG_V];
      pass = 1'b0;
      case (cond)
         EQ:      pass = z;
         NE:      pass = ~z;
         CS:      pass = c;
         CC:      pass = ~c;
         MI:      pass = n;
         PL:      pass = ~n;
         VS:      pass = v;
         VC:      pass = ~v;
         HI:      pass = c & ~z;
         LS:      pass = ~c | z;
         GE:      pass = (n == v);
         LT:      pass = (n != v);
         GT:      pass = ~z & (n == v);
         LE:      pass = z | (n != v);
         AL:      pass = 1'b1;
         default: pass = 1'b0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/cond_flags_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cond_flags_stage : E->M stage holding NZCV and gating write/branch controls|
// | Optional saturating squash counter enabled by COND_SQUASH_CNT_EN.          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module cond_flags_stage
   import cond_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  wire logic          clk,
   input  wire logic          reset,
   cond_flags_stage_if.slave  bus
);

   logic [3:0] flags_q;
   logic [3:0] flags_d;
   m_ctl_t     m_q;
   m_ctl_t     m_d;
   logic       cond_pass;
   logic       go;

   // Condition always uses the registered flags, giving the 1-cycle flag latency.
   cond_check u_cond_check (
      .cond  (cond_t'(bus.cond_e)),
      .flags (flags_q),
      .pass  (cond_pass)
   );

   always_comb begin
      go      = bus.valid_e & cond_pass & ~bus.flush;
      flags_d = flags_q;
      m_d     = m_q;
      if (bus.en) begin
         if (go && bus.flag_w_e[FW_NZ]) begin
            flags_d[FLAG_N] = bus.alu_flags[FLAG_N];
            flags_d[FLAG_Z] = bus.alu_flags[FLAG_Z];
         end
         if (go && bus.flag_w_e[FW_CV]) begin
            flags_d[FLAG_V] = bus.alu_flags[FLAG_V];
            flags_d[FLAG_C] = arm_carry(bus.alu_flags[FLAG_C], bus.alu_sub);
         end
         m_d.pcs   = go & bus.pcs_e;
         m_d.reg_w = go & bus.reg_w_e & ~bus.no_write_e;
         m_d.mem_w = go & bus.mem_w_e;
         m_d.valid = go;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         flags_q <= 4'b0000;
         m_q     <= '0;
      end else begin
         flags_q <= flags_d;
         m_q     <= m_d;
      end
   end

   assign bus.cond_ex_e = cond_pass;
   assign bus.flags_q   = flags_q;
   assign bus.pcs_m     = m_q.pcs;
   assign bus.reg_w_m   = m_q.reg_w;
   assign bus.mem_w_m   = m_q.mem_w;
   assign bus.valid_m   = m_q.valid;

`ifdef COND_SQUASH_CNT_EN
   logic [CNT_W-1:0] squash_cnt_q;
   logic [CNT_W-1:0] squash_cnt_d;

   always_comb begin
      squash_cnt_d = squash_cnt_q;
      if (bus.en && bus.valid_e && !bus.flush && !cond_pass && (squash_cnt_q != '1)) begin
         squash_cnt_d = squash_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         squash_cnt_q <= '0;
      end else begin
         squash_cnt_q <= squash_cnt_d;
      end
   end

   assign bus.squash_cnt = squash_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cond_flags_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cond_flags_stage : directed + randomized checks against a flag model    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_cond_flags_stage;

`ifdef COND_SQUASH_CNT_EN
   localparam int CNT_W = 2;
`else
   localparam int CNT_W = 16;
`endif

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   cond_flags_stage_if #(.CNT_W(CNT_W)) bus ();

   cond_flags_stage #(.CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference state: flags as separate booleans, expected M outputs, counter
   bit mz, mn, mc, mv;
   bit e_pcs, e_reg_w, e_mem_w, e_valid;
   int e_cnt;
   bit model_ok = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit cond_ok(input logic [3:0] c, input bit z, input bit n, input bit cy, input bit v);
      bit tbl [16];
      tbl[0]  = z;            tbl[1]  = !z;
      tbl[2]  = cy;           tbl[3]  = !cy;
      tbl[4]  = n;            tbl[5]  = !n;
      tbl[6]  = v;            tbl[7]  = !v;
      tbl[8]  = cy && !z;     tbl[9]  = !cy || z;
      tbl[10] = (n == v);     tbl[11] = (n != v);
      tbl[12] = !z && (n == v);
      tbl[13] = z || (n != v);
      tbl[14] = 1'b1;         tbl[15] = 1'b0;
      return tbl[c];
   endfunction

   function automatic logic [3:0] model_flags();
      return {mv, mc, mn, mz};
   endfunction

   task automatic model_step();
      bit pass, go;
      int cnt_max;
      cnt_max = (1 << CNT_W) - 1;
      if (reset) begin
         {mz, mn, mc, mv} = '0;
         {e_pcs, e_reg_w, e_mem_w, e_valid} = '0;
         e_cnt    = 0;
         model_ok = 1'b1;
      end else if (bus.en) begin
         pass = cond_ok(bus.cond_e, mz, mn, mc, mv);
         go   = bus.valid_e && pass && !bus.flush;
         if (bus.valid_e && !bus.flush && !pass && e_cnt < cnt_max) e_cnt++;
         if (go && bus.flag_w_e[1]) begin
            mn = bus.alu_flags[1];
            mz = bus.alu_flags[0];
         end
         if (go && bus.flag_w_e[0]) begin
            mv = bus.alu_flags[3];
            mc = bus.alu_sub ? !bus.alu_flags[2] : bus.alu_flags[2];
         end
         e_pcs   = go && bus.pcs_e;
         e_reg_w = go && bus.reg_w_e && !bus.no_write_e;
         e_mem_w = go && bus.mem_w_e;
         e_valid = go;
      end
   endtask

   // The single per-cycle compare point: negedge, then advance the model and the clock.
   task automatic tick();
      @(negedge clk);
      if (model_ok) begin
         chk("flags_q",   bus.flags_q,   model_flags());
         chk("cond_ex_e", bus.cond_ex_e, cond_ok(bus.cond_e, mz, mn, mc, mv));
         chk("pcs_m",     bus.pcs_m,     e_pcs);
         chk("reg_w_m",   bus.reg_w_m,   e_reg_w);
         chk("mem_w_m",   bus.mem_w_m,   e_mem_w);
         chk("valid_m",   bus.valid_m,   e_valid);
`ifdef COND_SQUASH_CNT_EN
         chk("squash_cnt", bus.squash_cnt, e_cnt);
`endif
      end
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_instr(input logic [3:0] c, input logic [1:0] fw, input logic [3:0] af,
                            input logic sub, input logic rw);
      bus.valid_e    = 1'b1;
      bus.cond_e     = c;
      bus.flag_w_e   = fw;
      bus.alu_flags  = af;
      bus.alu_sub    = sub;
      bus.reg_w_e    = rw;
      bus.pcs_e      = 1'b0;
      bus.mem_w_e    = 1'b0;
      bus.no_write_e = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      bus.en = 1'b1;
      bus.flush = 1'b0;
      set_instr(4'hE, 2'b00, 4'h0, 1'b0, 1'b1);

      // Reset, then an AL instruction with a register write
      tick();
      chk("t1_flags_rst", bus.flags_q, 4'b0000);
      chk("t1_valid_rst", bus.valid_m, 1'b0);
      reset = 1'b0;
      tick();
      chk("t1_reg_w_m", bus.reg_w_m, 1'b1);
      chk("t1_valid_m", bus.valid_m, 1'b1);

      // SUB 5-5: Z=1, no borrow -> C=1
      set_instr(4'hE, 2'b11, 4'b0001, 1'b1, 1'b0);
      tick();
      chk("t2_flags", bus.flags_q, 4'b0101);
      set_instr(4'h0, 2'b00, 4'h0, 1'b0, 1'b1);
      #1 chk("t2_eq_pass", bus.cond_ex_e, 1'b1);
      tick();
      chk("t2_eq_reg_w", bus.reg_w_m, 1'b1);
      set_instr(4'h1, 2'b00, 4'h0, 1'b0, 1'b1);
      tick();
      chk("t2_ne_reg_w", bus.reg_w_m, 1'b0);

      // V=1, N=0: LT passes, GE fails, NV never executes
      set_instr(4'hE, 2'b11, 4'b1000, 1'b0, 1'b0);
      tick();
      chk("t3_flags", bus.flags_q, 4'b1000);
      set_instr(4'hB, 2'b00, 4'h0, 1'b0, 1'b1);
      #1 chk("t3_lt", bus.cond_ex_e, 1'b1);
      set_instr(4'hA, 2'b00, 4'h0, 1'b0, 1'b1);
      #1 chk("t3_ge", bus.cond_ex_e, 1'b0);
      set_instr(4'hF, 2'b00, 4'h0, 1'b0, 1'b1);
      tick();
      chk("t3_nv_reg_w", bus.reg_w_m, 1'b0);

      // Stall holds everything; flush bubbles M without touching flags
      set_instr(4'hE, 2'b00, 4'h0, 1'b0, 1'b1);
      tick();
      bus.en = 1'b0;
      set_instr(4'hE, 2'b11, 4'hF, 1'b0, 1'b0);
      tick();
      chk("t4_stall_flags", bus.flags_q, 4'b1000);
      chk("t4_stall_reg_w", bus.reg_w_m, 1'b1);
      bus.en = 1'b1;
      bus.flush = 1'b1;
      tick();
      chk("t4_flush_valid", bus.valid_m, 1'b0);
      chk("t4_flush_flags", bus.flags_q, 4'b1000);
      bus.flush = 1'b0;

      // CMP-class: flags update, no register write
      set_instr(4'hE, 2'b11, 4'b0010, 1'b0, 1'b1);
      bus.no_write_e = 1'b1;
      tick();
      chk("t5_reg_w", bus.reg_w_m, 1'b0);
      chk("t5_valid", bus.valid_m, 1'b1);
      chk("t5_flags", bus.flags_q, 4'b0010);

`ifdef COND_SQUASH_CNT_EN
      reset = 1'b1;
      tick();
      reset = 1'b0;
      set_instr(4'hF, 2'b00, 4'h0, 1'b0, 1'b1);
      tick(); chk("t6_cnt1", bus.squash_cnt, 1);
      tick(); chk("t6_cnt2", bus.squash_cnt, 2);
      tick(); chk("t6_cnt3", bus.squash_cnt, 3);
      tick(); chk("t6_cnt4", bus.squash_cnt, 3);
      tick(); chk("t6_cnt5", bus.squash_cnt, 3);
      reset = 1'b1;
      bus.en = 1'b0;
      tick(); chk("t6_cnt_rst", bus.squash_cnt, 0);
      reset = 1'b0;
      bus.en = 1'b1;
`endif

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         reset          = ($urandom_range(0, 49) == 0);
         bus.en         = ($urandom_range(0, 9) < 8);
         bus.flush      = ($urandom_range(0, 9) < 2);
         bus.valid_e    = ($urandom_range(0, 9) < 8);
         bus.cond_e     = 4'($urandom_range(0, 15));
         bus.flag_w_e   = 2'($urandom_range(0, 3));
         bus.alu_flags  = 4'($urandom_range(0, 15));
         bus.alu_sub    = 1'($urandom_range(0, 1));
         bus.pcs_e      = 1'($urandom_range(0, 1));
         bus.reg_w_e    = 1'($urandom_range(0, 1));
         bus.mem_w_e    = 1'($urandom_range(0, 1));
         bus.no_write_e = 1'($urandom_range(0, 1));
         tick();
      end
      reset = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
